// File: rtl/note_pkg.sv
// Shared mode encodings and default widths for the monophonic note-priority block.
package note_pkg;

  typedef enum logic [1:0] {
    PRIO_HIGH = 2'd0,
    PRIO_LOW  = 2'd1,
    PRIO_LAST = 2'd2
  } prio_e;

  localparam int unsigned DEF_NOTE_W = 7;
  localparam int unsigned DEF_VEL_W  = 7;

endpackage

// File: rtl/note_prio_enc.sv
// Combinational highest/lowest set-bit finder: dir=0 returns the highest index, dir=1 the lowest.
module note_prio_enc #(
  parameter int unsigned WIDTH = 128,
  localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] vec,
  input  logic             dir,
  output logic [IDX_W-1:0] idx_c,
  output logic             valid_c
);

  // Later matches overwrite earlier ones, so scan order sets the priority.
  always_comb begin
    idx_c   = '0;
    valid_c = |vec;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (!dir && vec[i]) idx_c = IDX_W'(i);
      if (dir && vec[int'(WIDTH) - 1 - i]) idx_c = IDX_W'(int'(WIDTH) - 1 - i);
    end
  end

endmodule

// File: rtl/note_mono_prio.sv
// Monophonic note selector: key bitmap plus ordered last-note stack, with high/low/last priority.
module note_mono_prio
  import note_pkg::*;
#(
  parameter int unsigned STACK_DEPTH = 8,
  parameter int unsigned NOTE_W      = DEF_NOTE_W,
  parameter int unsigned VEL_W       = DEF_VEL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              note_on,
  input  logic              note_off,
  input  logic [NOTE_W-1:0] note,
  input  logic [VEL_W-1:0]  velocity,
  input  logic [1:0]        mode,
  output logic [NOTE_W-1:0] out_note,
  output logic [VEL_W-1:0]  out_vel,
  output logic              out_gate,
  output logic              out_retrig,
  output logic              out_evict
);

  localparam int unsigned KEYS  = 2 ** NOTE_W;
  localparam int unsigned CNT_W = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IDX_W = $clog2(STACK_DEPTH);

  logic [KEYS-1:0]   bitmap, bitmap_n;
  logic [NOTE_W-1:0] stk_note   [STACK_DEPTH];
  logic [VEL_W-1:0]  stk_vel    [STACK_DEPTH];
  logic [NOTE_W-1:0] stk_note_n [STACK_DEPTH];
  logic [VEL_W-1:0]  stk_vel_n  [STACK_DEPTH];
  logic [CNT_W-1:0]  cnt, cnt_n;

  logic              held, evict_n, repress;
  logic [IDX_W-1:0]  pos, top, top_n;
  logic [NOTE_W-1:0] enc_idx, sel_note;
  logic [VEL_W-1:0]  sel_vel;
  logic              gate_n, retrig_n;

  // Next bitmap/stack: push, move-to-top, evict-oldest or remove-and-compact.
  always_comb begin
    bitmap_n = bitmap;
    cnt_n    = cnt;
    evict_n  = 1'b0;
    repress  = 1'b0;
    pos      = '0;
    for (int i = 0; i < int'(STACK_DEPTH); i++) begin
      stk_note_n[i] = stk_note[i];
      stk_vel_n[i]  = stk_vel[i];
      if (int'(cnt) > i && stk_note[i] == note) pos = IDX_W'(i);
    end
    held = bitmap[note];
    top  = IDX_W'(cnt - CNT_W'(1));

    if (note_on) begin
      if (held) begin
        for (int i = 0; i < int'(STACK_DEPTH) - 1; i++) begin
          if (i >= int'(pos) && i < int'(cnt) - 1) begin
            stk_note_n[i] = stk_note[i+1];
            stk_vel_n[i]  = stk_vel[i+1];
          end
        end
        stk_note_n[top] = note;
        stk_vel_n[top]  = velocity;
        repress         = out_gate && (note == out_note);
      end else if (int'(cnt) == int'(STACK_DEPTH)) begin
        bitmap_n[stk_note[0]] = 1'b0;
        for (int i = 0; i < int'(STACK_DEPTH) - 1; i++) begin
          stk_note_n[i] = stk_note[i+1];
          stk_vel_n[i]  = stk_vel[i+1];
        end
        stk_note_n[STACK_DEPTH-1] = note;
        stk_vel_n[STACK_DEPTH-1]  = velocity;
        bitmap_n[note]            = 1'b1;
        evict_n                   = 1'b1;
      end else begin
        stk_note_n[IDX_W'(cnt)] = note;
        stk_vel_n[IDX_W'(cnt)]  = velocity;
        cnt_n                   = cnt + CNT_W'(1);
        bitmap_n[note]          = 1'b1;
      end
    end else if (note_off && held) begin
      for (int i = 0; i < int'(STACK_DEPTH) - 1; i++) begin
        if (i >= int'(pos) && i < int'(cnt) - 1) begin
          stk_note_n[i] = stk_note[i+1];
          stk_vel_n[i]  = stk_vel[i+1];
        end
      end
      stk_note_n[top] = '0;
      stk_vel_n[top]  = '0;
      cnt_n           = cnt - CNT_W'(1);
      bitmap_n[note]  = 1'b0;
    end
  end

  note_prio_enc #(
    .WIDTH (KEYS)
  ) u_enc (
    .vec     (bitmap_n),
    .dir     (mode == PRIO_LOW),
    .idx_c   (enc_idx),
    .valid_c (gate_n)
  );

  // Selection runs on the post-event state so outputs land one clock after the strobe.
  always_comb begin
    top_n    = IDX_W'(cnt_n - CNT_W'(1));
    sel_note = (mode == PRIO_HIGH || mode == PRIO_LOW) ? enc_idx : stk_note_n[top_n];
    sel_vel  = '0;
    for (int i = 0; i < int'(STACK_DEPTH); i++) begin
      if (int'(cnt_n) > i && stk_note_n[i] == sel_note) sel_vel = stk_vel_n[i];
    end
    retrig_n = gate_n && (!out_gate || sel_note != out_note || repress);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      bitmap     <= '0;
      cnt        <= '0;
      out_note   <= '0;
      out_vel    <= '0;
      out_gate   <= 1'b0;
      out_retrig <= 1'b0;
      out_evict  <= 1'b0;
      for (int i = 0; i < int'(STACK_DEPTH); i++) begin
        stk_note[i] <= '0;
        stk_vel[i]  <= '0;
      end
    end else begin
      bitmap     <= bitmap_n;
      cnt        <= cnt_n;
      out_gate   <= gate_n;
      out_retrig <= retrig_n;
      out_evict  <= evict_n;
      for (int i = 0; i < int'(STACK_DEPTH); i++) begin
        stk_note[i] <= stk_note_n[i];
        stk_vel[i]  <= stk_vel_n[i];
      end
      // Note/velocity hold through the release phase.
      if (gate_n) begin
        out_note <= sel_note;
        out_vel  <= sel_vel;
      end
    end
  end

endmodule

// File: tb/tb_note_mono_prio.sv
// Directed self-checking bench for note_mono_prio with hand-computed expectations.
module tb_note_mono_prio;

  logic       clk = 1'b0;
  logic       rst;
  logic       note_on, note_off;
  logic [6:0] note, velocity;
  logic [1:0] mode;
  logic [6:0] out_note, out_vel;
  logic       out_gate, out_retrig, out_evict;

  int n_checks = 0;
  int n_fail   = 0;

  note_mono_prio #(
    .STACK_DEPTH (8),
    .NOTE_W      (7),
    .VEL_W       (7)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .note_on    (note_on),
    .note_off   (note_off),
    .note       (note),
    .velocity   (velocity),
    .mode       (mode),
    .out_note   (out_note),
    .out_vel    (out_vel),
    .out_gate   (out_gate),
    .out_retrig (out_retrig),
    .out_evict  (out_evict)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Apply one cycle of strobes, then sample just after the capturing edge.
  task automatic ev(input logic on, input logic off, input int n, input int v);
    note_on  = on;
    note_off = off;
    note     = 7'(n);
    velocity = 7'(v);
    @(posedge clk);
    #1;
    note_on  = 1'b0;
    note_off = 1'b0;
  endtask

  task automatic idle();
    ev(1'b0, 1'b0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic expect_out(input string tag, input int n, input int v, input int g,
                            input int rt, input int evt);
    check({tag, ".note"},   int'(out_note),   n);
    check({tag, ".vel"},    int'(out_vel),    v);
    check({tag, ".gate"},   int'(out_gate),   g);
    check({tag, ".retrig"}, int'(out_retrig), rt);
    check({tag, ".evict"},  int'(out_evict),  evt);
  endtask

  initial begin
    rst = 1'b0; note_on = 1'b0; note_off = 1'b0; note = '0; velocity = '0; mode = 2'd0;
    @(posedge clk); #1;
    do_reset();
    expect_out("reset", 0, 0, 0, 0, 0);

    // Highest-note priority.
    mode = 2'd0;
    ev(1, 0, 60, 100); expect_out("hi_on60", 60, 100, 1, 1, 0);
    ev(1, 0, 64, 50);  expect_out("hi_on64", 64, 50, 1, 1, 0);
    ev(1, 0, 62, 30);  expect_out("hi_on62", 64, 50, 1, 0, 0);
    ev(0, 1, 64, 0);   expect_out("hi_off64", 62, 30, 1, 1, 0);
    idle();            expect_out("hi_idle", 62, 30, 1, 0, 0);
    ev(0, 1, 60, 0);   expect_out("hi_off60", 62, 30, 1, 0, 0);
    ev(0, 1, 62, 0);   expect_out("hi_off62", 62, 30, 0, 0, 0);

    // Last-note priority and release hold.
    mode = 2'd2;
    ev(1, 0, 60, 10);  expect_out("last_on60", 60, 10, 1, 1, 0);
    ev(1, 0, 67, 90);  expect_out("last_on67", 67, 90, 1, 1, 0);
    ev(0, 1, 67, 0);   expect_out("last_off67", 60, 10, 1, 1, 0);
    ev(0, 1, 60, 0);   expect_out("last_off60", 60, 10, 0, 0, 0);

    // Fill the stack, then evict the oldest.
    for (int k = 40; k < 48; k++) ev(1, 0, k, k);
    expect_out("full_47", 47, 47, 1, 1, 0);
    ev(1, 0, 50, 5);   expect_out("evict_on50", 50, 5, 1, 1, 1);
    idle();            expect_out("evict_idle", 50, 5, 1, 0, 0);
    ev(0, 1, 40, 0);   expect_out("off_evicted40", 50, 5, 1, 0, 0);
    mode = 2'd1;
    idle();            expect_out("low_after_evict", 41, 41, 1, 1, 0);
    ev(1, 0, 41, 77);  expect_out("repress41", 41, 77, 1, 1, 0);

    // Reset mid-hold with a strobe that must be discarded.
    rst = 1'b0;
    ev(1, 0, 90, 9);   expect_out("rst_hold", 0, 0, 0, 0, 0);
    rst = 1'b1;
    idle();            expect_out("rst_exit", 0, 0, 0, 0, 0);
    mode = 2'd2;
    ev(1, 0, 70, 12);  expect_out("post_rst_on70", 70, 12, 1, 1, 0);
    do_reset();

    // Simultaneous on/off, then a mode change re-evaluates.
    mode = 2'd1;
    ev(1, 1, 55, 33);  expect_out("onoff55", 55, 33, 1, 1, 0);
    ev(1, 0, 52, 20);  expect_out("low_on52", 52, 20, 1, 1, 0);
    mode = 2'd0;
    idle();            expect_out("mode_to_hi", 55, 33, 1, 1, 0);
    ev(0, 1, 99, 0);   expect_out("off_unheld99", 55, 33, 1, 0, 0);
    mode = 2'd3;
    idle();            expect_out("mode3_last", 52, 20, 1, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
